regread_arbiter: RTL and testbench

REGREAD_ARBITER -- requirements
Module: regread_arbiter

---
 rtl/regread_arbiter_pkg.sv | 14 +
 rtl/regread_arbiter_rr_arbiter4.sv | 29 ++
 rtl/regread_arbiter.sv | 78 +++++++
 tb/tb_regread_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regread_arbiter_pkg.sv
// Shared constants and state encoding for the register-read arbiter.
// Imported by the arbiter top and its round-robin grant sub-module.
package regread_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NREQ       = 4;
    localparam int unsigned GNT_IDX_W  = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/regread_arbiter_rr_arbiter4.sv
// Four-way round-robin grant: searches upward from last+1 (mod 4) and returns
// a one-hot grant plus its encoded index. No grant when en is low.
module rr_arbiter4
    import regread_arbiter_pkg::*;
(
    input  logic [3:0]           valid,
    input  logic [GNT_IDX_W-1:0] last,
    input  logic                 en,
    output logic [3:0]           gnt,
    output logic [GNT_IDX_W-1:0] idx
);

    logic [GNT_IDX_W-1:0] w_cand;

    // Walk candidates from lowest priority to highest so the nearest one wins.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        w_cand = '0;
        for (int k = 3; k >= 0; k--) begin
            w_cand = last + GNT_IDX_W'(k + 1);
            if (en && valid[w_cand]) begin
                gnt = 4'b0001 << w_cand;
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/regread_arbiter.sv
// Arbitrates four requesters onto one external register read mux and holds a
// single registered response per owner; sustains one read per cycle.
module regread_arbiter #(
    parameter int unsigned N    = 32,
    parameter int unsigned NREQ = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NREQ-1:0]                              req_valid,
    input  logic [regread_arbiter_pkg::REG_ADDR_W*NREQ-1:0] req_addr,
    output logic [NREQ-1:0]                              req_ready,
    output logic [regread_arbiter_pkg::REG_ADDR_W-1:0]   mux_sl,
    input  logic [N-1:0]                                 mux_out,
    output logic [NREQ-1:0]                              rsp_valid,
    input  logic [NREQ-1:0]                              rsp_ready,
    output logic [N-1:0]                                 rsp_data
);

    import regread_arbiter_pkg::*;

    state_e               r_state;
    logic [NREQ-1:0]      r_rsp_valid;
    logic [N-1:0]         r_rsp_data;
    logic [GNT_IDX_W-1:0] r_last;

    logic                  w_accept;
    logic                  w_en;
    logic                  w_xfer;
    logic [NREQ-1:0]       w_gnt;
    logic [GNT_IDX_W-1:0]  w_idx;
    logic [REG_ADDR_W-1:0] w_sel;

    // Only the owner's rsp_ready bit can accept; other bits are masked out.
    assign w_accept = (r_state == FULL) && |(r_rsp_valid & rsp_ready);
    assign w_en     = rst_n && ((r_state == EMPTY) || w_accept);
    assign w_xfer   = |w_gnt;

    rr_arbiter4 u_rr (
        .valid (req_valid),
        .last  (r_last),
        .en    (w_en),
        .gnt   (w_gnt),
        .idx   (w_idx)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_last      <= GNT_IDX_W'(NREQ - 1);
        end else if (w_xfer) begin
            // Register x0 is hardwired zero regardless of what the mux returns.
            r_state     <= FULL;
            r_rsp_valid <= w_gnt;
            r_rsp_data  <= (w_sel == '0) ? '0 : mux_out;
            r_last      <= w_idx;
        end else if (w_accept) begin
            r_state     <= EMPTY;
            r_rsp_valid <= '0;
        end
    end

    assign req_ready = w_gnt;
    assign mux_sl    = w_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_regread_arbiter.sv
// Bench for regread_arbiter: hand-derived vector table plus an independent
// reference model whose expected responses are tracked in a scoreboard queue.
module tb_regread_arbiter;

    localparam int unsigned N = 8;

    typedef struct {
        logic        rst_n;
        logic [3:0]  v;
        logic [19:0] addr;
        logic [3:0]  rr;
        logic        ff;
        logic [3:0]  e_ready;
        logic [4:0]  e_sl;
        logic [3:0]  e_rv;
        logic [7:0]  e_rd;
        logic        chk_rd;
    } vec_t;

    typedef struct packed {
        logic [3:0] owner;
        logic [7:0] data;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [19:0]  req_addr;
    logic [3:0]   req_ready;
    logic [4:0]   mux_sl;
    logic [N-1:0] mux_out;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [N-1:0] rsp_data;
    logic         mux_ff;

    int n_checks = 0;
    int n_fail   = 0;

    rsp_t       sb_q[$];
    logic [1:0] m_last;
    vec_t       tbl[23];

    localparam logic [19:0] A_DEF = {5'd12, 5'd7, 5'd9, 5'd5};
    localparam logic [19:0] A_X0  = {5'd12, 5'd7, 5'd9, 5'd0};

    always #5 clk = ~clk;

    // Behavioural stand-in for the external register read mux.
    assign mux_out = mux_ff ? 8'hFF : 8'(mux_sl * 3);

    regread_arbiter #(.N(N), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .mux_sl    (mux_sl),
        .mux_out   (mux_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare against the reference model, then advance it across the coming edge.
    task automatic model_step();
        logic       full, accept, allowed, granted;
        logic [3:0] e_gnt;
        logic [4:0] e_sl;
        logic [7:0] e_data;
        int         idx;
        full    = (sb_q.size() != 0);
        accept  = full && ((sb_q[0].owner & rsp_ready) != 4'b0);
        allowed = rst_n && (!full || accept);
        granted = 1'b0;
        e_gnt   = 4'b0;
        e_sl    = 5'd0;
        idx     = 0;
        for (int k = 1; k <= 4; k++) begin
            idx = (int'(m_last) + k) % 4;
            if (allowed && !granted && req_valid[idx]) begin
                granted    = 1'b1;
                e_gnt[idx] = 1'b1;
                e_sl       = req_addr[idx*5 +: 5];
            end
        end
        e_data = (e_sl == 5'd0) ? 8'd0 : (mux_ff ? 8'hFF : 8'(e_sl * 3));
        chk("model_req_ready", 32'(req_ready), 32'(e_gnt));
        chk("model_mux_sl", 32'(mux_sl), 32'(e_sl));
        if (full) begin
            chk("sb_rsp_valid", 32'(rsp_valid), 32'(sb_q[0].owner));
            chk("sb_rsp_data", 32'(rsp_data), 32'(sb_q[0].data));
        end else begin
            chk("sb_rsp_idle", 32'(rsp_valid), 32'd0);
        end
        if (!rst_n) begin
            sb_q.delete();
            m_last = 2'd3;
        end else begin
            if (accept) void'(sb_q.pop_front());
            if (granted) begin
                sb_q.push_back('{owner: e_gnt, data: e_data});
                for (int i = 0; i < 4; i++) if (e_gnt[i]) m_last = 2'(i);
            end
        end
    endtask

    task automatic apply(input vec_t r, input bit use_tbl, input int row);
        rst_n     = r.rst_n;
        req_valid = r.v;
        req_addr  = r.addr;
        rsp_ready = r.rr;
        mux_ff    = r.ff;
        #3;
        if (use_tbl) begin
            chk($sformatf("row%0d_req_ready", row), 32'(req_ready), 32'(r.e_ready));
            chk($sformatf("row%0d_mux_sl", row), 32'(mux_sl), 32'(r.e_sl));
            chk($sformatf("row%0d_rsp_valid", row), 32'(rsp_valid), 32'(r.e_rv));
            if (r.chk_rd) chk($sformatf("row%0d_rsp_data", row), 32'(rsp_data), 32'(r.e_rd));
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rs, input logic [3:0] v, input logic [19:0] a,
                                input logic [3:0] rr, input logic ff, input logic [3:0] er,
                                input logic [4:0] es, input logic [3:0] erv,
                                input logic [7:0] erd, input logic crd);
        vec_t t;
        t = '{rst_n: rs, v: v, addr: a, rr: rr, ff: ff, e_ready: er, e_sl: es,
              e_rv: erv, e_rd: erd, chk_rd: crd};
        return t;
    endfunction

    initial begin
        vec_t rv;
        // Reset with every requester asking.
        tbl[0]  = mk(0, 4'b1111, A_DEF, 4'b0000, 0, 4'b0000, 5'd0,  4'b0000, 8'd0,  1);
        tbl[1]  = mk(1, 4'b1111, A_DEF, 4'b1111, 0, 4'b0001, 5'd5,  4'b0000, 8'd0,  1);
        // Single read of addr 7 by requester 2, overlapped with acceptance of req0.
        tbl[2]  = mk(1, 4'b0100, A_DEF, 4'b1111, 0, 4'b0100, 5'd7,  4'b0001, 8'd15, 1);
        tbl[3]  = mk(1, 4'b0000, A_DEF, 4'b1111, 0, 4'b0000, 5'd0,  4'b0100, 8'd21, 1);
        tbl[4]  = mk(1, 4'b0000, A_DEF, 4'b1111, 0, 4'b0000, 5'd0,  4'b0000, 8'd0,  0);
        // Fairness: everyone valid, everyone ready, one transfer per cycle.
        tbl[5]  = mk(1, 4'b1111, A_DEF, 4'b1111, 0, 4'b1000, 5'd12, 4'b0000, 8'd0,  0);
        tbl[6]  = mk(1, 4'b1111, A_DEF, 4'b1111, 0, 4'b0001, 5'd5,  4'b1000, 8'd36, 1);
        tbl[7]  = mk(1, 4'b1111, A_DEF, 4'b1111, 0, 4'b0010, 5'd9,  4'b0001, 8'd15, 1);
        tbl[8]  = mk(1, 4'b1111, A_DEF, 4'b1111, 0, 4'b0100, 5'd7,  4'b0010, 8'd27, 1);
        tbl[9]  = mk(1, 4'b1111, A_DEF, 4'b1111, 0, 4'b1000, 5'd12, 4'b0100, 8'd21, 1);
        tbl[10] = mk(1, 4'b1111, A_DEF, 4'b1111, 0, 4'b0001, 5'd5,  4'b1000, 8'd36, 1);
        // Backpressure: req1 owns the response and stalls; non-owner ready bits ignored.
        tbl[11] = mk(1, 4'b0010, A_DEF, 4'b0001, 0, 4'b0010, 5'd9,  4'b0001, 8'd15, 1);
        tbl[12] = mk(1, 4'b0101, A_DEF, 4'b1101, 0, 4'b0000, 5'd0,  4'b0010, 8'd27, 1);
        tbl[13] = mk(1, 4'b0101, A_DEF, 4'b1101, 0, 4'b0000, 5'd0,  4'b0010, 8'd27, 1);
        tbl[14] = mk(1, 4'b0101, A_DEF, 4'b1101, 0, 4'b0000, 5'd0,  4'b0010, 8'd27, 1);
        tbl[15] = mk(1, 4'b0101, A_DEF, 4'b0010, 0, 4'b0100, 5'd7,  4'b0010, 8'd27, 1);
        tbl[16] = mk(1, 4'b0000, A_DEF, 4'b0100, 0, 4'b0000, 5'd0,  4'b0100, 8'd21, 1);
        // x0 read with an all-ones mux, then reset while FULL.
        tbl[17] = mk(1, 4'b0001, A_X0,  4'b0000, 1, 4'b0001, 5'd0,  4'b0000, 8'd0,  0);
        tbl[18] = mk(1, 4'b0000, A_X0,  4'b0000, 1, 4'b0000, 5'd0,  4'b0001, 8'd0,  1);
        tbl[19] = mk(0, 4'b1111, A_X0,  4'b0000, 1, 4'b0000, 5'd0,  4'b0001, 8'd0,  1);
        tbl[20] = mk(1, 4'b0000, A_DEF, 4'b1111, 0, 4'b0000, 5'd0,  4'b0000, 8'd0,  1);
        tbl[21] = mk(1, 4'b1111, A_DEF, 4'b0000, 0, 4'b0001, 5'd5,  4'b0000, 8'd0,  1);
        tbl[22] = mk(1, 4'b0000, A_DEF, 4'b0001, 0, 4'b0000, 5'd0,  4'b0001, 8'd15, 1);

        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_addr  = A_DEF;
        rsp_ready = 4'b0000;
        mux_ff    = 1'b0;
        m_last    = 2'd3;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) apply(tbl[i], 1'b1, i);

        // Random traffic checked only against the reference model.
        for (int i = 0; i < 400; i++) begin
            rv = mk(($urandom_range(0, 24) != 0), 4'($urandom), 20'($urandom),
                    4'($urandom), ($urandom_range(0, 7) == 0), 4'b0, 5'd0, 4'b0, 8'd0, 0);
            apply(rv, 1'b0, i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
